// File: rtl/lb_pkg.sv
// -----------------------------------------------------------------------------
// lb_pkg
// Shared definitions for the line-buffer frame sequencer family: the frame
// FSM state encoding, default geometry of the 4-line-buffer window
// controller, and a helper giving the number of window rows a frame yields.
// -----------------------------------------------------------------------------
package lb_pkg;

    localparam int LINE_W_DEF   = 256;
    localparam int LB_COUNT_DEF = 4;
    localparam int IMG_H_DEF    = 256;
    localparam int WIN_ROWS_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } lb_state_e;

    // A WIN_ROWS-high window slides down IMG_H lines one row at a time.
    function automatic int expected_rows(input int img_h, input int win_rows);
        return img_h - win_rows + 1;
    endfunction

endpackage

// File: rtl/lb_credit_counter.sv
// -----------------------------------------------------------------------------
// lb_credit_counter
// Saturating up/down counter with reload and a sticky overflow flag.
//   clk, rst  : clock and synchronous active-high reset (count=MAX_VAL, flag=0)
//   reload    : load count with MAX_VAL (overflow flag is kept)
//   inc, dec  : step up / step down; both together leave the count unchanged
//   count     : current value, 0..MAX_VAL
//   overflow  : sticky, set when inc alone arrives at MAX_VAL; cleared by rst
// -----------------------------------------------------------------------------
module lb_credit_counter #(
    parameter int MAX_VAL = 4,
    parameter int CNT_W   = $clog2(MAX_VAL) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= MAX_CNT;
            r_overflow <= 1'b0;
        end else if (reload) begin
            r_count <= MAX_CNT;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (r_count == MAX_CNT) r_overflow <= 1'b1;
                    else                    r_count    <= r_count + CNT_W'(1);
                end
                2'b01: begin
                    // Underflow cannot happen when the consumer gates on count!=0.
                    if (r_count != '0) r_count <= r_count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/lb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// lb_frame_sequencer
// Feeds one IMG_H x LINE_W frame of 8-bit pixels into the 4-line-buffer window
// controller, throttled by line credit so no buffer is overwritten before its
// window row has been read. Credit is returned by the controller's end-of-row
// interrupt. After the last line it waits for all window rows, flushes the
// controller and pulses frame_done.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin a frame (only honoured in IDLE)
//   s_pixel/s_valid  : source pixel stream;  s_ready : sequencer accepts
//   lb_pixel/_valid  : pixel to controller (combinational pass-through)
//   lb_intr          : controller end-of-row pulse (returns one line credit)
//   lb_flush         : one-cycle controller flush at frame end
//   busy             : frame in progress;  frame_done : one-cycle completion
//   rows_out         : window rows seen this frame
//   credit_err       : sticky, credit return while credit was already full
// -----------------------------------------------------------------------------
module lb_frame_sequencer
    import lb_pkg::*;
#(
    parameter int LINE_W   = LINE_W_DEF,
    parameter int LB_COUNT = LB_COUNT_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int WIN_ROWS = WIN_ROWS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               s_pixel,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [7:0]               lb_pixel,
    output logic                     lb_pixel_valid,
    input  logic                     lb_intr,
    output logic                     lb_flush,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(IMG_H):0]   rows_out,
    output logic                     credit_err
);

    localparam int PIX_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LINE_CW = $clog2(IMG_H) + 1;
    localparam int CRED_W = $clog2(LB_COUNT) + 1;

    localparam logic [PIX_W-1:0]   LAST_PIX  = PIX_W'(LINE_W - 1);
    localparam logic [LINE_CW-1:0] LAST_LINE = LINE_CW'(IMG_H - 1);
    localparam logic [LINE_CW-1:0] ROWS_EXP  = LINE_CW'(expected_rows(IMG_H, WIN_ROWS));

    lb_state_e          r_state;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [LINE_CW-1:0] r_line_cnt;
    logic [LINE_CW-1:0] r_rows_out;

    logic [CRED_W-1:0]  w_credit;
    logic               w_accept;
    logic               w_line_end;
    logic               w_frame_end;
    logic               w_in_frame;
    logic               w_intr_eff;
    logic               w_reload;
    logic [LINE_CW-1:0] w_rows_next;

    // Interrupts only count while a frame is actually using the controller;
    // in IDLE and DONE they are stale and must not disturb credit or rows.
    assign w_in_frame  = (r_state == ST_STREAM) || (r_state == ST_DRAIN) ||
                         (r_state == ST_FLUSH);
    assign w_intr_eff  = lb_intr && w_in_frame;
    assign w_reload    = (r_state == ST_IDLE) && start;

    assign s_ready     = (r_state == ST_STREAM) && (w_credit != '0);
    assign w_accept    = s_valid && s_ready;
    assign w_line_end  = w_accept && (r_pix_cnt == LAST_PIX);
    assign w_frame_end = w_line_end && (r_line_cnt == LAST_LINE);
    assign w_rows_next = r_rows_out + (w_intr_eff ? LINE_CW'(1) : LINE_CW'(0));

    lb_credit_counter #(
        .MAX_VAL (LB_COUNT),
        .CNT_W   (CRED_W)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .reload   (w_reload),
        .inc      (w_intr_eff),
        .dec      (w_line_end),
        .count    (w_credit),
        .overflow (credit_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_rows_out <= '0;
        end else begin
            r_rows_out <= w_rows_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pix_cnt  <= '0;
                        r_line_cnt <= '0;
                        r_rows_out <= '0;
                        r_state    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        if (w_line_end) begin
                            r_pix_cnt  <= '0;
                            r_line_cnt <= r_line_cnt + LINE_CW'(1);
                        end else begin
                            r_pix_cnt  <= r_pix_cnt + PIX_W'(1);
                        end
                    end
                    if (w_frame_end) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Include an interrupt landing this cycle so the last row
                    // does not cost an extra cycle.
                    if (w_rows_next >= ROWS_EXP) r_state <= ST_FLUSH;
                end
                ST_FLUSH: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign lb_pixel       = s_pixel;
    assign lb_pixel_valid = w_accept;
    assign busy           = w_in_frame;
    assign lb_flush       = (r_state == ST_FLUSH);
    assign frame_done     = (r_state == ST_DONE);
    assign rows_out       = r_rows_out;

endmodule

// File: tb/tb_lb_frame_sequencer.sv
module tb_lb_frame_sequencer;

    localparam int LW  = 8;
    localparam int LB  = 4;
    localparam int IH  = 6;
    localparam int WR  = 3;
    localparam int EXP = IH - WR + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_pixel = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] lb_pixel;
    logic       lb_pixel_valid;
    logic       lb_intr = 1'b0;
    logic       lb_flush;
    logic       busy;
    logic       frame_done;
    logic [3:0] rows_out;
    logic       credit_err;

    lb_frame_sequencer #(
        .LINE_W   (LW),
        .LB_COUNT (LB),
        .IMG_H    (IH),
        .WIN_ROWS (WR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_pixel        (s_pixel),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .lb_pixel       (lb_pixel),
        .lb_pixel_valid (lb_pixel_valid),
        .lb_intr        (lb_intr),
        .lb_flush       (lb_flush),
        .busy           (busy),
        .frame_done     (frame_done),
        .rows_out       (rows_out),
        .credit_err     (credit_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_flush = 0;
    int n_done = 0;
    int flush_cyc = -1;
    int done_cyc = -1;

    // Reference model: frame phase (0 idle,1 stream,2 drain,3 flush,4 done),
    // position in frame, rows seen and line credit as plain integers.
    int m_phase = 0;
    int m_pix = 0;
    int m_line = 0;
    int m_rows = 0;
    int m_credit = LB;
    bit m_err = 1'b0;

    // Controller model: window row ready some cycles after each line >= WR-1.
    bit auto_intr = 1'b0;
    int intr_jitter = 0;
    int intr_q[$];

    function automatic bit pop_intr();
        if (intr_q.size() > 0 && intr_q[0] <= cyc) begin
            void'(intr_q.pop_front());
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input bit st, input bit v, input bit intr, input bit rs);
        logic [7:0] px;
        logic [9:0] exp_vec;
        logic [9:0] act_vec;
        bit exp_ready, exp_acc, intr_eff, line_end;
        px = 8'($urandom);
        start = st; s_valid = v; s_pixel = px; lb_intr = intr; rst = rs;
        @(negedge clk);
        exp_ready = (m_phase == 1) && (m_credit > 0);
        exp_acc   = v && exp_ready;
        exp_vec = {exp_ready, exp_acc, (m_phase >= 1 && m_phase <= 3), (m_phase == 3),
                   (m_phase == 4), m_err, 4'(m_rows)};
        act_vec = {s_ready, lb_pixel_valid, busy, lb_flush, frame_done, credit_err, rows_out};
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_err++;
            $display("FAIL outputs cyc=%0d {rdy,pv,busy,flush,done,cerr,rows} got=%b exp=%b",
                     cyc, act_vec, exp_vec);
        end
        if (exp_acc) begin
            n_cmp++;
            if (lb_pixel !== px) begin
                n_err++;
                $display("FAIL pixel cyc=%0d got=%h exp=%h", cyc, lb_pixel, px);
            end
        end
        if (lb_pixel_valid === 1'b1) n_acc++;
        if (lb_flush === 1'b1) begin n_flush++; flush_cyc = cyc; end
        if (frame_done === 1'b1) begin n_done++; done_cyc = cyc; end

        if (rs) begin
            m_phase = 0; m_pix = 0; m_line = 0; m_rows = 0; m_credit = LB; m_err = 1'b0;
        end else begin
            intr_eff = intr && (m_phase >= 1 && m_phase <= 3);
            line_end = exp_acc && (m_pix == LW - 1);
            if (auto_intr && line_end && m_line >= WR - 1)
                intr_q.push_back(cyc + 8 + intr_jitter);
            m_credit = m_credit - int'(line_end) + int'(intr_eff);
            if (m_credit > LB) begin m_credit = LB; m_err = 1'b1; end
            m_rows += int'(intr_eff);
            case (m_phase)
                0: if (st) begin
                       m_phase = 1; m_pix = 0; m_line = 0; m_rows = 0; m_credit = LB;
                   end
                1: if (exp_acc) begin
                       if (line_end) begin
                           m_pix = 0; m_line++;
                           if (m_line == IH) m_phase = 2;
                       end else m_pix++;
                   end
                2: if (m_rows >= EXP) m_phase = 3;
                3: m_phase = 4;
                default: m_phase = 0;
            endcase
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        intr_q.delete();
        n_acc = 0; n_flush = 0; n_done = 0; flush_cyc = -1; done_cyc = -1;
        auto_intr = 1'b1; intr_jitter = 0;
    endtask

    task automatic run_frame(input bit do_start, input int vprob, input bit start_on_done,
                             input bit jitter);
        int d0;
        d0 = n_done;
        if (do_start) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 800 && n_done == d0; i++) begin
            if (jitter) intr_jitter = $urandom_range(6);
            step(start_on_done && (m_phase == 4), ($urandom_range(99) < vprob), pop_intr(), 1'b0);
        end
        n_cmp++;
        if (n_done == d0) begin
            n_err++;
            $display("FAIL frame_timeout got=no frame_done exp=frame_done within 800 cycles");
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (dut.w_credit !== 3'd4) begin
            n_err++; $display("FAIL reset_credit got=%0d exp=4", dut.w_credit);
        end
        n_cmp++;
        if ({s_ready, lb_pixel_valid, lb_flush, busy, frame_done, rows_out, credit_err} !== 10'd0) begin
            n_err++; $display("FAIL reset_outputs got=%b exp=0",
                {s_ready, lb_pixel_valid, lb_flush, busy, frame_done, rows_out, credit_err});
        end
    endtask

    task automatic test_nominal();
        do_reset();
        run_frame(1'b1, 100, 1'b0, 1'b0);
        n_cmp++;
        if (n_acc != IH * LW) begin n_err++; $display("FAIL nom_pixels got=%0d exp=%0d", n_acc, IH * LW); end
        n_cmp++;
        if (rows_out !== 4'(EXP)) begin n_err++; $display("FAIL nom_rows got=%0d exp=%0d", rows_out, EXP); end
        n_cmp++;
        if (n_flush != 1) begin n_err++; $display("FAIL nom_flush_count got=%0d exp=1", n_flush); end
        n_cmp++;
        if (done_cyc != flush_cyc + 1) begin
            n_err++; $display("FAIL nom_done_after_flush got=%0d exp=%0d", done_cyc, flush_cyc + 1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL nom_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_credit_stall();
        do_reset();
        auto_intr = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (n_acc != 4 * LW) begin n_err++; $display("FAIL stall_accepts got=%0d exp=%0d", n_acc, 4 * LW); end
        n_cmp++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got=%b exp=0", s_ready); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL stall_resume got=%b exp=1", s_ready); end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (n_acc != 5 * LW) begin n_err++; $display("FAIL stall_one_line got=%0d exp=%0d", n_acc, 5 * LW); end
        n_cmp++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL stall_again got=%b exp=0", s_ready); end
    endtask

    task automatic test_simultaneous_and_spurious();
        do_reset();
        auto_intr = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LW - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (dut.w_credit !== 3'd4) begin n_err++; $display("FAIL simul_credit got=%0d exp=4", dut.w_credit); end
        n_cmp++;
        if (credit_err !== 1'b0) begin n_err++; $display("FAIL simul_err got=%b exp=0", credit_err); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (credit_err !== 1'b1) begin n_err++; $display("FAIL spur_err got=%b exp=1", credit_err); end
        n_cmp++;
        if (dut.w_credit !== 3'd4) begin n_err++; $display("FAIL spur_credit got=%0d exp=4", dut.w_credit); end
        auto_intr = 1'b1;
        run_frame(1'b0, 100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (credit_err !== 1'b1) begin n_err++; $display("FAIL spur_sticky got=%b exp=1", credit_err); end
    endtask

    task automatic test_ignored_controls();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({rows_out, credit_err, busy} !== 6'd0 || dut.w_credit !== 3'd4) begin
            n_err++; $display("FAIL idle_intr got=rows%0d,err%b,busy%b,cr%0d exp=0,0,0,4",
                              rows_out, credit_err, busy, dut.w_credit);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (n_acc != 4 || busy !== 1'b1) begin
            n_err++; $display("FAIL stream_start got=acc%0d,busy%b exp=acc4,busy1", n_acc, busy);
        end
        run_frame(1'b0, 100, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || rows_out !== 4'(EXP)) begin
            n_err++; $display("FAIL done_start got=busy%b,rdy%b,rows%0d exp=busy0,rdy0,rows%0d",
                              busy, s_ready, rows_out, EXP);
        end
    endtask

    task automatic test_rst_mid_frame();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60 && n_acc < 2 * LW + 3; i++) step(1'b0, 1'b1, pop_intr(), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({s_ready, lb_pixel_valid, lb_flush, busy, frame_done, rows_out, credit_err} !== 10'd0
            || dut.w_credit !== 3'd4) begin
            n_err++; $display("FAIL rst_mid got=%b,cr%0d exp=0,cr4",
                {s_ready, lb_pixel_valid, lb_flush, busy, frame_done, rows_out, credit_err}, dut.w_credit);
        end
        n_cmp++;
        if (n_flush != 0) begin n_err++; $display("FAIL rst_no_flush got=%0d exp=0", n_flush); end
        do_reset();
        run_frame(1'b1, 100, 1'b0, 1'b0);
        n_cmp++;
        if (n_acc != IH * LW || n_flush != 1 || rows_out !== 4'(EXP)) begin
            n_err++; $display("FAIL rst_reframe got=acc%0d,fl%0d,rows%0d exp=acc%0d,fl1,rows%0d",
                              n_acc, n_flush, rows_out, IH * LW, EXP);
        end
    endtask

    task automatic test_back_to_back_random();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            n_acc = 0;
            run_frame(1'b1, 40 + $urandom_range(59), 1'b0, 1'b1);
            n_cmp++;
            if (n_acc != IH * LW) begin
                n_err++; $display("FAIL rand_frame%0d_pixels got=%0d exp=%0d", f, n_acc, IH * LW);
            end
        end
        n_cmp++;
        if (n_done != 3 || n_flush != 3) begin
            n_err++; $display("FAIL rand_frames got=done%0d,flush%0d exp=3,3", n_done, n_flush);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_nominal();
        test_credit_stall();
        test_simultaneous_and_spurious();
        test_ignored_controls();
        test_rst_mid_frame();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
